// File: rtl/m_spi_core.sv
// m_spi_core: SPI master with byte register map and single-entry TX buffer.
// Define M_SPI_LOOPBACK_EN to enable CONTROL[2] internal MOSI->MISO loopback.
module m_spi_core #(
   parameter int SS_WIDTH = 8
) (
   input  logic                I_CLK,
   input  logic                I_RESETN,
   input  logic                I_TX_EN,
   input  logic [2:0]          I_WADDR,
   input  logic [7:0]          I_WDATA,
   input  logic                I_RX_EN,
   input  logic [2:0]          I_RADDR,
   output logic [7:0]          O_RDATA,
   output logic                O_SCLK,
   output logic                O_MOSI,
   input  logic                I_MISO,
   output logic [SS_WIDTH-1:0] O_SS_N
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LEAD  = 2'd1;
   localparam logic [1:0] ST_SHIFT = 2'd2;
   localparam logic [1:0] ST_TRAIL = 2'd3;
   localparam logic [7:0] SS_KEEP  = 8'((9'd1 << SS_WIDTH) - 9'd1);

   logic [1:0] state;
   logic [3:0] cnt;
   logic [3:0] half;
   logic       spe, cpol, cpha, msbf;
   logic [1:0] div;
   logic       a_cpol, a_cpha, a_msbf;
   logic [1:0] a_div;
   logic [7:0] ssmask, tx_buf, tx_sr, rx_sr, rx_data, rdata;
   logic       tx_empty, rx_rdy, ovr;

   logic       wr_ctl, wr_tx, wr_ss, rd_rx, rd_st;
   logic       spe_nxt, busy, abort, start;
   logic       last, evt, done, samp, miso_in, loop_rd;
   logic [3:0] hm1, half_nxt;
   logic [2:0] bit_no, tx_idx, rx_idx;
   logic [7:0] rd_val;

   assign wr_ctl = I_TX_EN && (I_WADDR == 3'd3);
   assign wr_tx  = I_TX_EN && (I_WADDR == 3'd1);
   assign wr_ss  = I_TX_EN && (I_WADDR == 3'd4);
   assign rd_rx  = I_RX_EN && (I_RADDR == 3'd0);
   assign rd_st  = I_RX_EN && (I_RADDR == 3'd2);

   // Clearing SPE aborts on the same edge that captures the write
   assign spe_nxt = wr_ctl ? I_WDATA[7] : spe;
   assign busy    = state != ST_IDLE;
   assign abort   = busy && !spe_nxt;
   assign start   = !busy && spe && !tx_empty;

   assign hm1      = 4'((5'd2 << a_div) - 5'd1);
   assign last     = cnt == hm1;
   assign evt      = last && (state == ST_LEAD ||
                     (state == ST_SHIFT && half != 4'd15));
   assign half_nxt = (state == ST_LEAD) ? 4'd0 : half + 4'd1;
   assign done     = (state == ST_TRAIL) && last && !abort;

   // Edge into an even half samples for CPHA=0, odd half for CPHA=1
   assign samp   = evt && !abort && (half_nxt[0] == a_cpha);
   assign rx_idx = a_msbf ? 3'd7 - half_nxt[3:1] : half_nxt[3:1];

   always_comb begin
      bit_no = 3'd0;
      unique case (state)
         ST_SHIFT: begin
            if (a_cpha)
               bit_no = half[3:1];
            else if (half == 4'd15)
               bit_no = 3'd7;
            else
               bit_no = half_nxt[3:1];
         end
         ST_TRAIL: bit_no = 3'd7;
         default:  bit_no = 3'd0;
      endcase
   end

   assign tx_idx = a_msbf ? 3'd7 - bit_no : bit_no;
   assign O_MOSI = busy & tx_sr[tx_idx];
   assign O_SCLK = (state == ST_SHIFT) ? (a_cpol ^ ~half[0]) :
                   (busy ? a_cpol : cpol);
   assign O_SS_N = busy ? ~ssmask[SS_WIDTH-1:0] : '1;
   assign O_RDATA = rdata;

`ifdef M_SPI_LOOPBACK_EN
   logic loop;

   always_ff @(posedge I_CLK or negedge I_RESETN) begin
      if (!I_RESETN)
         loop <= 1'b0;
      else if (wr_ctl)
         loop <= I_WDATA[2];
   end

   assign loop_rd = loop;
   assign miso_in = loop ? O_MOSI : I_MISO;
`else
   assign loop_rd = 1'b0;
   assign miso_in = I_MISO;
`endif

   always_comb begin
      rd_val = 8'h00;
      unique case (I_RADDR)
         3'd0:    rd_val = rx_data;
         3'd1:    rd_val = tx_buf;
         3'd2:    rd_val = {ovr, rx_rdy, tx_empty, !busy, 4'b0};
         3'd3:    rd_val = {spe, 1'b0, cpol, cpha, msbf, loop_rd, div};
         3'd4:    rd_val = ssmask;
         default: rd_val = 8'h00;
      endcase
   end

   always_ff @(posedge I_CLK or negedge I_RESETN) begin
      if (!I_RESETN) begin
         state    <= ST_IDLE;
         cnt      <= 4'd0;
         half     <= 4'd0;
         spe      <= 1'b0;
         cpol     <= 1'b0;
         cpha     <= 1'b0;
         msbf     <= 1'b0;
         div      <= 2'd0;
         a_cpol   <= 1'b0;
         a_cpha   <= 1'b0;
         a_msbf   <= 1'b0;
         a_div    <= 2'd0;
         ssmask   <= 8'h00;
         tx_buf   <= 8'h00;
         tx_sr    <= 8'h00;
         rx_sr    <= 8'h00;
         rx_data  <= 8'h00;
         rdata    <= 8'h00;
         tx_empty <= 1'b1;
         rx_rdy   <= 1'b0;
         ovr      <= 1'b0;
      end else begin
         if (abort) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
         end else begin
            unique case (state)
               ST_IDLE: begin
                  if (start) begin
                     state  <= ST_LEAD;
                     cnt    <= 4'd0;
                     a_cpol <= cpol;
                     a_cpha <= cpha;
                     a_msbf <= msbf;
                     a_div  <= div;
                     tx_sr  <= tx_buf;
                  end
               end
               ST_LEAD: begin
                  if (last) begin
                     state <= ST_SHIFT;
                     cnt   <= 4'd0;
                     half  <= 4'd0;
                  end else
                     cnt <= cnt + 4'd1;
               end
               ST_SHIFT: begin
                  if (last) begin
                     cnt <= 4'd0;
                     if (half == 4'd15)
                        state <= ST_TRAIL;
                     else
                        half <= half + 4'd1;
                  end else
                     cnt <= cnt + 4'd1;
               end
               default: begin
                  if (last) begin
                     state <= ST_IDLE;
                     cnt   <= 4'd0;
                  end else
                     cnt <= cnt + 4'd1;
               end
            endcase
         end

         if (samp)
            rx_sr[rx_idx] <= miso_in;
         if (done)
            rx_data <= rx_sr;

         if (wr_tx)
            tx_empty <= 1'b0;
         else if (start || abort)
            tx_empty <= 1'b1;
         if (wr_tx)
            tx_buf <= I_WDATA;

         if (done)
            rx_rdy <= 1'b1;
         else if (rd_rx)
            rx_rdy <= 1'b0;
         if (done && rx_rdy)
            ovr <= 1'b1;
         else if (rd_st)
            ovr <= 1'b0;

         if (wr_ctl) begin
            spe  <= I_WDATA[7];
            cpol <= I_WDATA[5];
            cpha <= I_WDATA[4];
            msbf <= I_WDATA[3];
            div  <= I_WDATA[1:0];
         end
         if (wr_ss)
            ssmask <= I_WDATA & SS_KEEP;
         if (I_RX_EN)
            rdata <= rd_val;
      end
   end

endmodule
